// File: rtl/cnt_mon_pkg.sv
// Shared constants for the counter-sequence monitor: mode selects, FSM state
// encodings and the seed value each counter family starts from.
package cnt_mon_pkg;

  localparam logic [1:0] MODE_BIN  = 2'd0;
  localparam logic [1:0] MODE_RING = 2'd1;
  localparam logic [1:0] MODE_JOHN = 2'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEEK   = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  localparam logic [3:0] SEED_BIN  = 4'b0000;
  localparam logic [3:0] SEED_RING = 4'b0001;
  localparam logic [3:0] SEED_JOHN = 4'b0000;

endpackage

// File: rtl/cnt_seq_next.sv
// Combinational successor/seed lookup for the 4-bit counter family.
// Mode 3 is not a distinct sequence and falls back to binary.
module cnt_seq_next
  import cnt_mon_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] x,
  output logic [3:0] nxt,
  output logic [3:0] seed
);

  // successor and seed per selected sequence
  always_comb begin
    nxt  = x + 4'd1;
    seed = SEED_BIN;
    case (mode)
      MODE_RING: begin
        nxt  = {x[2:0], x[3]};
        seed = SEED_RING;
      end
      MODE_JOHN: begin
        nxt  = {x[2:0], ~x[3]};
        seed = SEED_JOHN;
      end
      default: begin
        nxt  = x + 4'd1;
        seed = SEED_BIN;
      end
    endcase
  end

endmodule

// File: rtl/cnt_seq_monitor.sv
// Checks that a counter's output follows its legal sequence, declares lock
// after LOCK_CNT good transitions and counts every loss of lock.
module cnt_seq_monitor
  import cnt_mon_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_clr,
  input  logic [3:0]       i_cnt,
  output logic             o_lock,
  output logic             o_err,
  output logic             o_wrap,
  output logic [ERR_W-1:0] o_err_cnt
);

  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q,   state_d;
  logic [1:0]       mode_q,    mode_d;
  logic [3:0]       prev_q,    prev_d;
  logic [3:0]       run_q,     run_d;
  logic             lock_q,    lock_d;
  logic             err_q,     err_d;
  logic             wrap_q,    wrap_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [3:0] nxt_s;
  logic [3:0] seed_s;
  logic [3:0] run_inc_s;
  logic       good_s;

  cnt_seq_next u_next (
    .mode (mode_q),
    .x    (prev_q),
    .nxt  (nxt_s),
    .seed (seed_s)
  );

  assign good_s    = (i_cnt == nxt_s);
  assign run_inc_s = run_q + 4'd1;

  // FSM next state, run length, wrap/error pulses and saturating error count
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    run_d   = run_q;
    prev_d  = i_cnt;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    // disable takes priority over any mismatch seen on the same edge
    if (!i_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SEEK;
          mode_d  = i_mode;
        end
        ST_SEEK: begin
          if (i_cnt == seed_s) begin
            state_d = ST_CHECK;
            run_d   = 4'd0;
          end else begin
            state_d = ST_SEEK;
          end
        end
        ST_CHECK: begin
          if (good_s) begin
            run_d = run_inc_s;
            if (run_inc_s == LOCK_TGT) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_CHECK;
            end
          end else begin
            state_d = ST_SEEK;
          end
        end
        ST_LOCKED: begin
          if (good_s) begin
            state_d = ST_LOCKED;
            wrap_d  = (i_cnt == seed_s);
          end else begin
            state_d = ST_SEEK;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    lock_d = (state_d == ST_LOCKED);

    if (i_clr) begin
      err_cnt_d = {ERR_W{1'b0}};
    end else if (err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_BIN;
      prev_q    <= 4'd0;
      run_q     <= 4'd0;
      lock_q    <= 1'b0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= {ERR_W{1'b0}};
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_lock    = lock_q;
  assign o_err     = err_q;
  assign o_wrap    = wrap_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// Directed bench for cnt_seq_monitor (LOCK_CNT=4, ERR_W=2): the driver queues
// the expected outputs for each sample and a monitor compares after each edge.
module tb_cnt_seq_monitor;

  typedef struct packed {
    logic       lock;
    logic       err;
    logic       wrap;
    logic [1:0] ecnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_en;
  logic [1:0] i_mode;
  logic       i_clr;
  logic [3:0] i_cnt;
  logic       o_lock;
  logic       o_err;
  logic       o_wrap;
  logic [1:0] o_err_cnt;

  exp_t exp_q[$];
  exp_t exp_e;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] jseq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

  cnt_seq_monitor #(.LOCK_CNT(4), .ERR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_en      (i_en),
    .i_mode    (i_mode),
    .i_clr     (i_clr),
    .i_cnt     (i_cnt),
    .o_lock    (o_lock),
    .o_err     (o_err),
    .o_wrap    (o_wrap),
    .o_err_cnt (o_err_cnt)
  );

  always #5 clk = ~clk;

  // monitor: one expectation per edge, compared shortly after the edge
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      checks = checks + 1;
      if (o_lock !== exp_e.lock || o_err !== exp_e.err ||
          o_wrap !== exp_e.wrap || o_err_cnt !== exp_e.ecnt) begin
        errors = errors + 1;
        $display("FAIL outputs @%0t: actual lock=%0b err=%0b wrap=%0b cnt=%0d required lock=%0b err=%0b wrap=%0b cnt=%0d (i_cnt=%0h)",
                 $time, o_lock, o_err, o_wrap, o_err_cnt,
                 exp_e.lock, exp_e.err, exp_e.wrap, exp_e.ecnt, i_cnt);
      end
    end
  end

  task automatic step(input logic en, input logic [1:0] mode, input logic clr,
                      input logic [3:0] cnt, input logic lock, input logic err,
                      input logic wrap, input logic [1:0] ecnt);
    exp_t e;
    i_en   = en;
    i_mode = mode;
    i_clr  = clr;
    i_cnt  = cnt;
    e.lock = lock;
    e.err  = err;
    e.wrap = wrap;
    e.ecnt = ecnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // feed seed..4 in binary order; lock rises on the fourth good sample
  task automatic bin_lock(input logic [1:0] mode, input logic [1:0] ecnt);
    for (int v = 0; v <= 4; v++)
      step(1'b1, mode, 1'b0, 4'(v), (v == 4), 1'b0, 1'b0, ecnt);
  endtask

  initial begin
    exp_t r;
    rst    = 1'b1;
    i_en   = 1'b0;
    i_mode = 2'd0;
    i_clr  = 1'b0;
    i_cnt  = 4'd0;
    r = '0;
    exp_q.push_back(r);
    #22 rst = 1'b0;
    @(negedge clk);

    // binary lock and wrap; mode change while running must be ignored
    step(1'b1, 2'd0, 1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 36; i++)
      step(1'b1, (i >= 20) ? 2'd2 : 2'd0, 1'b0, 4'(i % 16),
           (i >= 4), 1'b0, (i >= 16 && (i % 16) == 0), 2'd0);

    // injected jump while locked, then relock
    step(1'b1, 2'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 2'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 2'd0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b1, 2'd0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 2'd1);
    for (int v = 10; v <= 15; v++)
      step(1'b1, 2'd0, 1'b0, 4'(v), 1'b0, 1'b0, 1'b0, 2'd1);
    bin_lock(2'd0, 2'd1);

    // stall while locked
    step(1'b1, 2'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b1, 2'd0, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 2'd2);

    // bad sample during CHECK: silent return to SEEK
    for (int v = 6; v <= 15; v++)
      step(1'b1, 2'd0, 1'b0, 4'(v), 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 2'd2);
    for (int v = 8; v <= 15; v++)
      step(1'b1, 2'd0, 1'b0, 4'(v), 1'b0, 1'b0, 1'b0, 2'd2);
    bin_lock(2'd0, 2'd2);

    // enable dropped while locked, with an otherwise-bad sample
    step(1'b0, 2'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b0, 2'd0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0, 2'd2);

    // ring: illegal values never reach seed, then period-4 wrap
    step(1'b1, 2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd1, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd1, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b0, 2'd2);
    for (int j = 0; j <= 12; j++)
      step(1'b1, 2'd1, 1'b0, 4'b0001 << (j % 4),
           (j >= 4), 1'b0, (j >= 8 && (j % 4) == 0), 2'd2);

    // johnson: period-8 wrap
    step(1'b0, 2'd2, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd2, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 2'd2);
    for (int j = 0; j <= 16; j++)
      step(1'b1, 2'd2, 1'b0, jseq[j % 8],
           (j >= 4), 1'b0, (j >= 8 && (j % 8) == 0), 2'd2);

    // mode 3 as binary, then saturation at 3 with five errors total
    step(1'b0, 2'd3, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd3, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 2'd2);
    for (int v = 0; v <= 5; v++)
      step(1'b1, 2'd3, 1'b0, 4'(v), (v >= 4), 1'b0, 1'b0, 2'd2);
    step(1'b1, 2'd3, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd3);
    for (int rep = 0; rep < 2; rep++) begin
      bin_lock(2'd3, 2'd3);
      step(1'b1, 2'd3, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 2'd3);
    end

    // clear coincident with an error wins
    bin_lock(2'd3, 2'd3);
    step(1'b1, 2'd3, 1'b1, 4'd9, 1'b0, 1'b1, 1'b0, 2'd0);
    bin_lock(2'd3, 2'd0);
    step(1'b1, 2'd3, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0, 2'd1);
    bin_lock(2'd3, 2'd1);

    // async reset pulse between edges while locked
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    step(1'b1, 2'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0);
    bin_lock(2'd0, 2'd0);
    for (int v = 5; v <= 16; v++)
      step(1'b1, 2'd0, 1'b0, 4'(v % 16), 1'b1, 1'b0, (v == 16), 2'd0);

    for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(posedge clk);
    #5;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnt_seq_monitor.md
# cnt_seq_monitor

Downstream checker for the 4-bit counter family (binary, circle/ring, johnson). It samples one counter's `o_cnt` every clock and checks that each sample is the legal successor of the previous one for the selected sequence. It declares lock after a run of correct transitions and flags every break in lock. It sits directly on the counter output bus and gives bring-up and regression a self-checking status instead of waveform inspection.

## Interface
- `LOCK_CNT`, default 4: consecutive legal transitions required to assert lock; range 1..15.
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_en`  in  1  monitor enable; low forces IDLE on the next edge.
- `i_mode`  in  2  sequence select: 0 binary, 1 ring (circle), 2 johnson, 3 treated as binary; latched on IDLE→SEEK.
- `i_clr`  in  1  synchronous clear of `o_err_cnt`.
- `i_cnt`  in  4  counter value under test.
- `o_lock`  out  1  high while in LOCKED.
- `o_err`  out  1  one-cycle pulse on each mismatch detected in LOCKED.
- `o_wrap`  out  1  one-cycle pulse on each legal transition into the seed value while LOCKED.
- `o_err_cnt`  out  ERR_W  number of `o_err` pulses, saturating.

## Operation
- Successor function `nxt(x)`:
  - binary: x+1 mod 16, seed 4'b0000.
  - ring: {x[2:0],x[3]}, seed 4'b0001.
  - johnson: {x[2:0],~x[3]}, seed 4'b0000.
- `prev_q` registers `i_cnt` every cycle, including in IDLE. A sample is "good" when `i_cnt == nxt(prev_q)`, evaluated with the latched mode `mode_q`.
- No legal sequence has a fixed point, so a stalled counter (`i_cnt == prev_q`) is always a mismatch.
- Ring mode: illegal non-one-hot values (e.g. 4'b0000, 4'b0011) never reach the seed, so the monitor stays in SEEK.
- States (2-bit):
  - IDLE: `i_en`=1 → SEEK; latch `i_mode` into `mode_q`.
  - SEEK: `i_cnt == seed` → CHECK, with `run_q` cleared to 0.
  - CHECK: on a good sample, `run_q`+1; when `run_q` reaches `LOCK_CNT` → LOCKED. On a bad sample → SEEK, with no `o_err`.
  - LOCKED: good sample → stay. Bad sample → SEEK, `o_err`=1, `o_err_cnt`+1 unless saturated.
- `i_en`=0 from any state → IDLE. It overrides all other transitions on the same edge, and no `o_err` is produced on that edge.
- `o_err_cnt` is not cleared by `i_en`. When `i_clr` and an error coincide, `i_clr` wins and the counter becomes 0.
- Saturation: at 2^ERR_W−1 further errors still pulse `o_err`, but the count holds.

## Timing
- Reset values: state IDLE, `prev_q`=0, `mode_q`=0, `run_q`=0, `o_lock`=0, `o_err`=0, `o_wrap`=0, `o_err_cnt`=0.
- Reset is asynchronous and applies immediately. Deassertion takes effect at the next rising edge. Reset mid-run drops lock with no `o_err`.
- All outputs are registered. A sample presented before edge N updates state at N, and its effect on outputs is visible after edge N.
- Lock latency: seed seen at edge N, then `LOCK_CNT` good samples at edges N+1..N+LOCK_CNT. `o_lock` rises after edge N+LOCK_CNT.
- `o_err` and the `o_lock` fall occur on the same edge as the bad sample. Re-lock needs the full SEEK→CHECK sequence again.
- `o_wrap` asserts on the edge where a good sample equals the seed, only in LOCKED. Expected periods: binary 16, ring 4, johnson 8 cycles.
- An `i_mode` change outside IDLE is ignored until the next pass through IDLE.

## Structure
- Package `cnt_mon_pkg` holds:
  - mode constants `MODE_BIN`, `MODE_RING`, `MODE_JOHN`;
  - state encodings `ST_IDLE`, `ST_SEEK`, `ST_CHECK`, `ST_LOCKED`;
  - seed constants per mode.
- Sub-module `cnt_seq_next` is purely combinational: (`mode`, `x`) → (`nxt`, `seed`). It is shared with any future counter model.
- Top level holds the FSM, `prev_q`, `run_q`, the error counter and the output registers.

## Test plan
- Binary lock and wrap: reset asserted 22 ns, `i_en`=1, mode 0, counter driving 0,1,2,... → `o_lock` high after 5th sample edge (seed + 4), `o_wrap` every 16 cycles thereafter, `o_err_cnt`=0.
- Ring and johnson: mode 1 fed 0001,0010,0100,1000 loop → `o_wrap` period 4. Mode 2 fed 0000,0001,0011,0111,1111,1110,1100,1000 → `o_wrap` period 8. Neither ever pulses `o_err`.
- Injected fault in LOCKED: binary 5,6,9 → `o_err` one pulse on the 9 edge, `o_lock`=0, `o_err_cnt`=1. Re-lock after the next 0 plus 4 good samples.
- Stall and CHECK abort: value 3 held two cycles while LOCKED → one `o_err`. Bad sample during CHECK → back to SEEK, `o_err_cnt` unchanged.
- Saturation and clear: `ERR_W`=2, 5 injected errors → `o_err_cnt`=3 with 5 `o_err` pulses. `i_clr` coincident with a 6th error → `o_err_cnt`=0.
- Control overrides: `i_en` dropped while LOCKED → IDLE, `o_lock`=0, no `o_err`. Async `rst` pulse between edges → all outputs 0 immediately. Mode 3 behaves as binary.
